// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, sequencer state encoding, PC source select
// and the opcode class bundle used by the control path.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

  // One-hot opcode class; exactly one field is set for any opcode.
  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic halt;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/ctrl_opclass.sv
// Opcode classifier: maps the raw 6-bit opcode onto a one-hot class so the
// sequencer's next-state logic only tests single bits.
module ctrl_opclass
  import cpu_defs::*;
(
  input  logic [5:0] op,
  output op_class_t  op_class
);

  // Pure decode; anything outside the known set is flagged illegal.
  always_comb begin
    op_class = '0;
    case (op)
      OP_RTYPE: op_class.rtype   = 1'b1;
      OP_LW:    op_class.load    = 1'b1;
      OP_SW:    op_class.store   = 1'b1;
      OP_BEQ:   op_class.branch  = 1'b1;
      OP_J:     op_class.jump    = 1'b1;
      OP_HALT:  op_class.halt    = 1'b1;
      default:  op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction sequencer for the single-issue datapath.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for run; all strobes low
// FETCH  | memory read of next instruction; IR/PC update on mem_ready
// DECODE | one cycle opcode dispatch; J, HALT and illegal retire here
// EXEC   | ALU cycle; BEQ resolves and retires here
// MEM    | load/store data access, held until mem_ready
// WB     | register write-back, retires RTYPE and LW
// HALT   | absorbing stop state, left only through reset
module cpu_ctrl
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        alu_en,
  output logic        reg_update,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instr_count,
  output logic        illegal,
  output logic        halted
);

  state_t     state_q;
  state_t     state_d;
  op_class_t  op_class;
  logic       set_illegal;
  logic [31:0] count_q;
  logic       illegal_q;
  logic       halted_q;

  ctrl_opclass u_opclass (
    .op       (op),
    .op_class (op_class)
  );

  // State, retire counter and sticky flags; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == ST_HALT);
      if (retire) begin
        count_q <= count_q + 32'd1;
      end
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next-state and datapath strobes; Mealy terms use mem_ready, op and zero.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    alu_en      = 1'b0;
    reg_update  = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          pc_sel  = PC_SEL_SEQ;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (op_class.jump) begin
          pc_load = 1'b1;
          pc_sel  = PC_SEL_JUMP;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (op_class.halt) begin
          retire  = 1'b1;
          state_d = ST_HALT;
        end else if (op_class.illegal) begin
          set_illegal = 1'b1;
          retire      = 1'b1;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        alu_en = 1'b1;
        if (op_class.rtype) begin
          state_d = ST_WB;
        end else if (op_class.load || op_class.store) begin
          state_d = ST_MEM;
        end else begin
          // BEQ; an opcode that changed after DECODE also lands here and
          // retires as a not-taken branch so the count stays consistent.
          retire = 1'b1;
          if (op_class.branch && zero) begin
            pc_load = 1'b1;
            pc_sel  = PC_SEL_BRANCH;
          end
          state_d = ST_FETCH;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = op_class.store;
        if (mem_ready) begin
          if (op_class.store) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        reg_update = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign illegal     = illegal_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction-level trace model with
// randomized memory wait states, branch outcomes and opcode mix.
module tb_cpu_ctrl;

  localparam logic [5:0] C_RTYPE = 6'h00;
  localparam logic [5:0] C_LW    = 6'h23;
  localparam logic [5:0] C_SW    = 6'h2B;
  localparam logic [5:0] C_BEQ   = 6'h04;
  localparam logic [5:0] C_J     = 6'h02;
  localparam logic [5:0] C_HALT  = 6'h3F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        ir_load;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        alu_en;
  logic        reg_update;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instr_count;
  logic        illegal;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count;
  bit          exp_illegal;

  cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_load     (ir_load),
    .pc_load     (pc_load),
    .pc_sel      (pc_sel),
    .alu_en      (alu_en),
    .reg_update  (reg_update),
    .state       (state),
    .retire      (retire),
    .instr_count (instr_count),
    .illegal     (illegal),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Runs one instruction starting in FETCH. The expected per-cycle phase list
  // comes from the instruction's class and the chosen wait counts; outputs
  // are compared every cycle at the falling edge.
  task automatic run_instr(input logic [5:0] o, input bit z, input int wf,
                           input int wm, input string name);
    int   st_q[$];
    bit   rdy_q[$];
    int   s;
    bit   r;
    bit   legal;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    logic [1:0] exp_sel;
    int   next_st;
    legal = (o == C_RTYPE) || (o == C_LW) || (o == C_SW) || (o == C_BEQ) ||
            (o == C_J) || (o == C_HALT);
    for (int i = 0; i < wf; i++) begin st_q.push_back(1); rdy_q.push_back(1'b0); end
    st_q.push_back(1); rdy_q.push_back(1'b1);
    st_q.push_back(2); rdy_q.push_back(1'b0);
    if (o == C_RTYPE) begin
      st_q.push_back(3); rdy_q.push_back(1'b0);
      st_q.push_back(5); rdy_q.push_back(1'b0);
    end else if (o == C_LW || o == C_SW) begin
      st_q.push_back(3); rdy_q.push_back(1'b0);
      for (int i = 0; i < wm; i++) begin st_q.push_back(4); rdy_q.push_back(1'b0); end
      st_q.push_back(4); rdy_q.push_back(1'b1);
      if (o == C_LW) begin st_q.push_back(5); rdy_q.push_back(1'b0); end
    end else if (o == C_BEQ) begin
      st_q.push_back(3); rdy_q.push_back(1'b0);
    end

    for (int k = 0; k < st_q.size(); k++) begin
      s = st_q[k];
      if (s == 1 || s == 4) r = rdy_q[k];
      else r = 1'($urandom_range(0, 1));
      mem_ready = r;
      op   = (s == 1) ? 6'($urandom_range(0, 63)) : o;
      zero = z;
      @(negedge clk);
      exp_v = {(s == 1 || s == 4), (s == 4 && o == C_SW), (s == 1 && r),
               ((s == 1 && r) || (s == 2 && o == C_J) || (s == 3 && o == C_BEQ && z)),
               (s == 3), (s == 5), (k == st_q.size() - 1), 1'b0};
      got_v = {mem_req, mem_we, ir_load, pc_load, alu_en, reg_update, retire, halted};
      checks++;
      if (state !== 3'(s)) begin
        errors++;
        $display("FAIL %s cyc%0d state: got %0d expected %0d", name, k, state, s);
      end
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cyc%0d strobes{req,we,ir,pcl,alu,ru,ret,hlt}: got %b expected %b",
                 name, k, got_v, exp_v);
      end
      if (exp_v[4]) begin
        exp_sel = (s == 2) ? 2'd2 : (s == 3) ? 2'd1 : 2'd0;
        checks++;
        if (pc_sel !== exp_sel) begin
          errors++;
          $display("FAIL %s cyc%0d pc_sel: got %0d expected %0d", name, k, pc_sel, exp_sel);
        end
      end
      @(posedge clk); #1;
    end

    exp_count = exp_count + 32'd1;
    if (!legal) exp_illegal = 1'b1;
    next_st = (o == C_HALT) ? 6 : 1;
    checks++;
    if (state !== 3'(next_st) || instr_count !== exp_count || illegal !== exp_illegal ||
        halted !== (o == C_HALT)) begin
      errors++;
      $display("FAIL %s end: state=%0d cnt=%0d ill=%b hlt=%b expected state=%0d cnt=%0d ill=%b hlt=%b",
               name, state, instr_count, illegal, halted, next_st, exp_count, exp_illegal,
               (o == C_HALT));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; op = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = '0;
    exp_illegal = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL start_run idle state: got %0d expected 0", state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (state !== 3'd0 || instr_count !== 32'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset regs: state=%0d cnt=%0d ill=%b hlt=%b expected 0 0 0 0",
               state, instr_count, illegal, halted);
    end
    checks++;
    if ({mem_req, mem_we, ir_load, pc_load, alu_en, reg_update, retire, pc_sel} !== 9'd0) begin
      errors++;
      $display("FAIL reset strobes: got %b expected 0",
               {mem_req, mem_we, ir_load, pc_load, alu_en, reg_update, retire, pc_sel});
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (state !== 3'd0) begin
        errors++;
        $display("FAIL idle_hold state: got %0d expected 0", state);
      end
    end
  endtask

  task automatic test_rtype();
    start_run();
    run_instr(C_RTYPE, 1'b0, 0, 0, "rtype");
  endtask

  task automatic test_lw_wait();
    run_instr(C_LW, 1'b0, 0, 3, "lw_wait");
  endtask

  task automatic test_beq();
    run_instr(C_BEQ, 1'b1, 0, 0, "beq_taken");
    run_instr(C_BEQ, 1'b0, 0, 0, "beq_not_taken");
    run_instr(C_J, 1'b0, 1, 0, "jump");
  endtask

  task automatic test_illegal_then_sw();
    run_instr(6'h15, 1'b0, 0, 0, "illegal");
    run_instr(C_SW, 1'b0, 0, 1, "sw_after_illegal");
  endtask

  task automatic test_random();
    logic [5:0] o;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: o = C_RTYPE;
        1: o = C_LW;
        2: o = C_SW;
        3: o = C_BEQ;
        4: o = C_J;
        default: begin
          case ($urandom_range(0, 3))
            0: o = 6'h15;
            1: o = 6'h01;
            2: o = 6'h3E;
            default: o = 6'h10;
          endcase
        end
      endcase
      run = 1'($urandom_range(0, 1));
      run_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    run_instr(C_RTYPE, 1'b0, 0, 0, "pre_abort");
    // Walk SW into a stalled MEM cycle, then pull reset.
    op = C_SW; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: state=%0d req=%b we=%b expected 4 1 1", state, mem_req, mem_we);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0 || mem_we !== 1'b0 || instr_count !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: state=%0d req=%b we=%b cnt=%0d expected 0 0 0 0",
               state, mem_req, mem_we, instr_count);
    end
    rst_n = 1'b1;
    exp_count = '0;
    exp_illegal = 1'b0;
  endtask

  task automatic test_halt();
    start_run();
    run_instr(C_SW, 1'b0, 2, 0, "sw_pre_halt");
    run_instr(C_HALT, 1'b0, 0, 0, "halt");
    for (int i = 0; i < 10; i++) begin
      run = 1'(i & 1);
      mem_ready = 1'($urandom_range(0, 1));
      op = 6'($urandom_range(0, 63));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (state !== 3'd6 || halted !== 1'b1 || instr_count !== exp_count ||
          {mem_req, mem_we, ir_load, pc_load, alu_en, reg_update, retire} !== 7'd0) begin
        errors++;
        $display("FAIL halt_hold: state=%0d hlt=%b cnt=%0d strobes=%b expected 6 1 %0d 0",
                 state, halted, instr_count,
                 {mem_req, mem_we, ir_load, pc_load, alu_en, reg_update, retire}, exp_count);
      end
      @(posedge clk); #1;
    end
    apply_reset();
    checks++;
    if (state !== 3'd0 || instr_count !== 32'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: state=%0d cnt=%0d hlt=%b expected 0 0 0",
               state, instr_count, halted);
    end
  endtask

  initial begin
    exp_count = '0;
    exp_illegal = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal_then_sw();
    test_random();
    test_reset_mid_mem();
    start_run();
    test_random();
    apply_reset();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Multi-cycle sequencer for the single-issue CPU datapath. Steps each instruction through FETCH, DECODE, EXEC, MEM and WB according to the 6-bit opcode from `decode`. Drives the datapath strobes: IR load, PC load/select, ALU enable, memory request and the `reg_update` write-back strobe into `decode`. Handles the memory wait handshake, branch resolution and halt.

## Interface
- `OP_RTYPE`, 6'h00: ALU register-register instruction
- `OP_LW`, 6'h23: load word
- `OP_SW`, 6'h2B: store word
- `OP_BEQ`, 6'h04: branch if equal
- `OP_J`, 6'h02: jump
- `OP_HALT`, 6'h3F: stop sequencing
- `clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `run`  in  1  start sequencing from IDLE
- `op`  in  6  opcode from `decode`; valid in DECODE and later states
- `zero`  in  1  ALU equality result; sampled in EXEC for BEQ
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  write qualifier for `mem_req`
- `ir_load`  out  1  latch the fetched word into IR
- `pc_load`  out  1  update PC
- `pc_sel`  out  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target
- `alu_en`  out  1  ALU operand/result capture
- `reg_update`  out  1  register-file write strobe into `decode`
- `state`  out  3  current state, for debug
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction
- `instr_count`  out  32  retired-instruction counter
- `illegal`  out  1  sticky flag: an unknown opcode was decoded
- `halted`  out  1  high while in HALT

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: all strobes low. Goes to FETCH when `run`=1.
- FETCH:
  - `mem_req`=1, `mem_we`=0.
  - Stays in FETCH while `mem_ready`=0.
  - On `mem_ready`=1, in the same cycle: `ir_load`=1 and `pc_load`=1 with `pc_sel`=0. Next state is DECODE.
- DECODE: one cycle; branches on `op`.
  - RTYPE, LW, SW, BEQ → EXEC.
  - J → `pc_load`=1, `pc_sel`=2, `retire`=1 → FETCH.
  - HALT → `retire`=1 → HALT.
  - Any other opcode → set `illegal`, `retire`=1 → FETCH. It is treated as a NOP.
- EXEC: `alu_en`=1.
  - RTYPE → WB.
  - LW, SW → MEM.
  - BEQ → `retire`=1 → FETCH. If `zero`=1 it also asserts `pc_load`=1 with `pc_sel`=1.
- MEM:
  - `mem_req`=1, with `mem_we`=1 for SW only.
  - Waits for `mem_ready`.
  - On `mem_ready`: LW → WB; SW → `retire`=1 → FETCH.
- WB: `reg_update`=1 and `retire`=1 for one cycle → FETCH.
- HALT: absorbing, `halted`=1. Only reset leaves it; `run` is ignored.
- `instr_count` increments by 1 on each `retire`. It wraps from 32'hFFFF_FFFF to 0.
- `run` is only sampled in IDLE. Deasserting it mid-program has no effect.

## Timing
- Reset (`rst_n`=0 at a rising edge): state=IDLE. `instr_count`=0, `illegal`=0. Every strobe output is 0, `pc_sel`=0, `halted`=0. Reset takes priority over every transition, including an in-flight `mem_req`. The memory must tolerate an abandoned request.
- `state`, `instr_count`, `illegal` and `halted` are registered.
- Strobes are combinational from the state. `ir_load`, `pc_load` and `retire` also depend on `mem_ready`, `op` and `zero` (Mealy) in the same cycle.
- Cycles per instruction with `mem_ready` tied high: RTYPE 4, LW 5, SW 4, BEQ 3, J 2, illegal 2.
- Each `mem_ready` wait cycle adds one cycle.
- `mem_req` stays stable high while waiting. It drops the cycle after the `mem_ready` acceptance.
- `mem_ready` is ignored outside FETCH and MEM.
- `reg_update` is never asserted in the same cycle as `mem_req`.

## Structure
- Shared package `cpu_defs` holds:
  - the opcode constants above,
  - the state encoding as a 3-bit typedef,
  - the `pc_sel` encodings.
  `decode` and the ALU reuse it.
- Optional sub-module `ctrl_opclass`: combinational `op` → one-hot class (rtype, load, store, branch, jump, halt, illegal). It keeps the FSM next-state logic flat.
- Everything else stays in one FSM with the counter and flag registers.

## Test plan
- Reset then `run`=1, RTYPE, `mem_ready` high → states 1,2,3,5,1. `reg_update` pulses in cycle 4. `instr_count`=1.
- LW with `mem_ready` low for 3 cycles in MEM → `mem_req`=1, `mem_we`=0 held for 4 cycles. WB follows. Total 8 cycles.
- BEQ with `zero`=1 → `pc_load`=1, `pc_sel`=1 in EXEC. With `zero`=0 → no `pc_load` in EXEC. Both retire after 3 cycles.
- Opcode 6'h15 → `illegal`=1 sticky, returns to FETCH, `instr_count` increments. A following valid SW completes with `mem_we`=1.
- HALT → `halted`=1, `retire` once. `run` toggling for 10 cycles has no effect. `rst_n`=0 → IDLE, `instr_count`=0.
- `rst_n` low during MEM wait of SW → next cycle IDLE, `mem_req`=0, `mem_we`=0.
